regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 107 ++++++++++
 tb/tb_regfile_sb.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard; ZERO_REG_EN hardwires register 0 to zero.
// Latency: read data and rd_valid one cycle after an accepted read; writes land at the edge.
// Backpressure: stall refuses reads of pending registers unless the same-cycle write supplies them.
module regfile_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    localparam int DEPTH = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_reg,
    input  logic [ADDR_W-1:0] rA,
    input  logic [ADDR_W-1:0] rB,
    output logic [DATA_W-1:0] regA,
    output logic [DATA_W-1:0] regB,
    output logic              rd_valid,
    output logic              stall,
    input  logic              issue,
    input  logic [ADDR_W-1:0] iss_rD,
    input  logic              regD_wr,
    input  logic [ADDR_W-1:0] rD,
    input  logic [DATA_W-1:0] regD,
    output logic [DEPTH-1:0]  busy
);

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_ok;
    logic              iss_ok;
    logic              clr_a;
    logic              clr_b;
    logic              accept;
    logic [DATA_W-1:0] rdat_a;
    logic [DATA_W-1:0] rdat_b;

    // Register 0 absorbs writes and issues when it is hardwired.
    assign wr_ok  = regD_wr && !(ZERO_REG && (rD == '0));
    assign iss_ok = issue && !(ZERO_REG && (iss_rD == '0));

    // A busy bit is only released when the write clears it and no issue re-reserves it.
    assign clr_a = wr_ok && (rD == rA) && !(iss_ok && (iss_rD == rA));
    assign clr_b = wr_ok && (rD == rB) && !(iss_ok && (iss_rD == rB));

    assign stall  = en_reg && ((busy[rA] && !clr_a) || (busy[rB] && !clr_b));
    assign accept = en_reg && !stall;

    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[rD] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[iss_rD] = 1'b1;
        end
    end

    always_comb begin
        rdat_a = mem[rA];
        if (ZERO_REG && (rA == '0)) begin
            rdat_a = '0;
        end else if (wr_ok && (rD == rA)) begin
            rdat_a = regD;
        end
    end

    always_comb begin
        rdat_b = mem[rB];
        if (ZERO_REG && (rB == '0)) begin
            rdat_b = '0;
        end else if (wr_ok && (rD == rB)) begin
            rdat_b = regD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[rD] <= regD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= '0;
            regA     <= '0;
            regB     <= '0;
            rd_valid <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            rd_valid <= accept;
            if (accept) begin
                regA <= rdat_a;
                regB <= rdat_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb; expectations follow ZERO_REG_EN when defined.
module tb_regfile_sb;

`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en_reg = 1'b0;
    logic [2:0]  rA = '0;
    logic [2:0]  rB = '0;
    logic [15:0] regA;
    logic [15:0] regB;
    logic        rd_valid;
    logic        stall;
    logic        issue = 1'b0;
    logic [2:0]  iss_rD = '0;
    logic        regD_wr = 1'b0;
    logic [2:0]  rD = '0;
    logic [15:0] regD = '0;
    logic [7:0]  busy;

    int n_chk = 0;
    int n_fail = 0;

    regfile_sb #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .en_reg(en_reg), .rA(rA), .rB(rB),
        .regA(regA), .regB(regB), .rd_valid(rd_valid), .stall(stall),
        .issue(issue), .iss_rD(iss_rD), .regD_wr(regD_wr), .rD(rD),
        .regD(regD), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        iss;
        logic [2:0]  iss_a;
        logic        wr;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        e_stall;
        logic [15:0] e_a;
        logic [15:0] e_b;
        logic        e_vld;
        logic [7:0]  e_busy;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic en, input logic [2:0] ra, input logic [2:0] rb,
                                input logic iss, input logic [2:0] iss_a,
                                input logic wr, input logic [2:0] wa, input logic [15:0] wd,
                                input logic e_stall, input logic [15:0] e_a, input logic [15:0] e_b,
                                input logic e_vld, input logic [7:0] e_busy);
        vec_t v;
        v.en = en; v.ra = ra; v.rb = rb; v.iss = iss; v.iss_a = iss_a;
        v.wr = wr; v.wa = wa; v.wd = wd; v.e_stall = e_stall;
        v.e_a = e_a; v.e_b = e_b; v.e_vld = e_vld; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        en_reg = 1'b0; rA = '0; rB = '0; issue = 1'b0; iss_rD = '0;
        regD_wr = 1'b0; rD = '0; regD = '0;
    endtask

    initial begin
        //          en ra rb iss ia wr wa wd        stall regA              regB              vld  busy
        vecs[0]  = mk(0, 0, 0, 0, 0, 1, 3, 16'hA5A5, 0, 16'h0000, 16'h0000, 0, 8'h00);
        vecs[1]  = mk(1, 3, 0, 0, 0, 0, 0, 16'h0000, 0, 16'hA5A5, 16'h0000, 1, 8'h00);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'hA5A5, 16'h0000, 0, 8'h00);
        vecs[3]  = mk(1, 5, 5, 0, 0, 1, 5, 16'h1234, 0, 16'h1234, 16'h1234, 1, 8'h00);
        vecs[4]  = mk(0, 0, 0, 1, 2, 0, 0, 16'h0000, 0, 16'h1234, 16'h1234, 0, 8'h04);
        vecs[5]  = mk(1, 2, 3, 0, 0, 0, 0, 16'h0000, 1, 16'h1234, 16'h1234, 0, 8'h04);
        vecs[6]  = mk(1, 2, 3, 0, 0, 1, 2, 16'h0042, 0, 16'h0042, 16'hA5A5, 1, 8'h00);
        vecs[7]  = mk(0, 0, 0, 1, 6, 1, 6, 16'hBEEF, 0, 16'h0042, 16'hA5A5, 0, 8'h40);
        vecs[8]  = mk(1, 6, 6, 0, 0, 0, 0, 16'h0000, 1, 16'h0042, 16'hA5A5, 0, 8'h40);
        vecs[9]  = mk(1, 1, 5, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h1234, 1, 8'h40);
        vecs[10] = mk(0, 0, 0, 0, 0, 1, 7, 16'h7777, 0, 16'h0000, 16'h1234, 0, 8'h40);
        vecs[11] = mk(1, 7, 7, 1, 6, 0, 0, 16'h0000, 0, 16'h7777, 16'h7777, 1, 8'h40);
        vecs[12] = mk(1, 6, 3, 0, 0, 1, 6, 16'h0066, 0, 16'h0066, 16'hA5A5, 1, 8'h00);
        vecs[13] = mk(0, 0, 0, 0, 0, 1, 0, 16'hFFFF, 0, 16'h0066, 16'hA5A5, 0, 8'h00);
        if (ZR) begin
            vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 8'h00);
            vecs[15] = mk(0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 8'h00);
            vecs[16] = mk(1, 0, 3, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hA5A5, 1, 8'h00);
            vecs[17] = mk(0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'hA5A5, 0, 8'h00);
            vecs[18] = mk(1, 0, 0, 0, 0, 1, 0, 16'h1111, 0, 16'h0000, 16'h0000, 1, 8'h00);
        end else begin
            vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 1, 8'h00);
            vecs[15] = mk(0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 0, 8'h01);
            vecs[16] = mk(1, 0, 3, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 16'hFFFF, 0, 8'h01);
            vecs[17] = mk(0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 0, 8'h00);
            vecs[18] = mk(1, 0, 0, 0, 0, 1, 0, 16'h1111, 0, 16'h1111, 16'h1111, 1, 8'h00);
        end

        // Reset state
        #2;
        chk("rst_regA", {16'h0, regA}, 32'h0);
        chk("rst_regB", {16'h0, regB}, 32'h0);
        chk("rst_vld", {31'h0, rd_valid}, 32'h0);
        chk("rst_busy", {24'h0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            en_reg = vecs[i].en; rA = vecs[i].ra; rB = vecs[i].rb;
            issue = vecs[i].iss; iss_rD = vecs[i].iss_a;
            regD_wr = vecs[i].wr; rD = vecs[i].wa; regD = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_regA", i), {16'h0, regA}, {16'h0, vecs[i].e_a});
            chk($sformatf("v%0d_regB", i), {16'h0, regB}, {16'h0, vecs[i].e_b});
            chk($sformatf("v%0d_vld", i), {31'h0, rd_valid}, {31'h0, vecs[i].e_vld});
            chk($sformatf("v%0d_busy", i), {24'h0, busy}, {24'h0, vecs[i].e_busy});
        end

        // Mid-cycle reset pulse: reserve r4 and load regA first so the clear is visible.
        @(negedge clk);
        idle_inputs();
        issue = 1'b1; iss_rD = 3'd4; en_reg = 1'b1; rA = 3'd3; rB = 3'd3;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", {24'h0, busy}, 32'h10);
        chk("pre_rst_regA", {16'h0, regA}, 32'hA5A5);
        @(negedge clk);
        idle_inputs();
        regD_wr = 1'b1; rD = 3'd1; regD = 16'hABCD; en_reg = 1'b1; rA = 3'd3;
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {24'h0, busy}, 32'h0);
        chk("arst_regA", {16'h0, regA}, 32'h0);
        chk("arst_vld", {31'h0, rd_valid}, 32'h0);
        #1;
        reset_n = 1'b1;
        idle_inputs();
        en_reg = 1'b1; rA = 3'd1; rB = 3'd3;
        #1;
        chk("post_rst_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_r1", {16'h0, regA}, 32'h0);
        chk("post_rst_r3", {16'h0, regB}, 32'h0);
        chk("post_rst_vld", {31'h0, rd_valid}, 32'h1);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("idle_vld", {31'h0, rd_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
